// File: rtl/mux_pkg.sv
// Shared encodings for the select arbiter and the downstream 2:1 mux.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_pkg;

    // Arbiter FSM state encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

    // Mux select values: 0 routes source A, 1 routes source B.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/beat_counter.sv
// Counts beats of the current grant and flags the final permitted beat.
// Latency: count updates on the edge after clear/enable; at_max decodes the register.
// Backpressure: none; saturates at MAX_BEATS-1 instead of wrapping.
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - restart the count at 0 (wins over enable)
//   enable    - add one beat
//   count     - current beat index within the grant
//   at_max    - count has reached MAX_BEATS-1
module beat_counter #(
    parameter int MAX_BEATS = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    assign at_max = (count == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !at_max) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/sel_arbiter.sv
// Round-robin owner of a 2:1 mux path with a per-grant beat cap and direct handoff.
// Latency: grant one edge after request; handoff on the release edge, no idle bubble.
// Backpressure: a source holds the mux until last, the beat cap, or dropping req.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   req_a, req_b      - source requests for the mux path
//   last              - final beat of the granted source
//   sel               - mux select (0 = A, 1 = B), held while idle
//   grant_a, grant_b  - ownership, one-hot or zero
//   busy              - a grant is active
// All outputs come straight from registers; no input reaches an output combinationally.
module sel_arbiter
    import mux_pkg::*;
#(
    parameter int MAX_BEATS = 8,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    output logic sel,
    output logic grant_a,
    output logic grant_b,
    output logic busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

    arb_state_t       state_q, state_d;
    logic             prio_q, prio_d;   // 0: A wins a tie, 1: B wins a tie
    logic             sel_q, sel_d;
    logic             cnt_clear, cnt_en;
    logic [CNT_W-1:0] beat_cnt;
    logic             cnt_at_max;
    logic             cap_hit;

    beat_counter #(
        .MAX_BEATS (MAX_BEATS),
        .CNT_W     (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (beat_cnt),
        .at_max (cnt_at_max)
    );

    // An out-of-range count (never reached in normal operation) also forces release,
    // so a corrupted counter can never extend a grant.
    assign cap_hit = cnt_at_max || (beat_cnt > LAST_CNT);

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        sel_d     = sel_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;

        case (state_q)
            IDLE: begin
                // last is irrelevant here: nothing is granted.
                if (req_a && (!req_b || !prio_q)) begin
                    state_d = OWN_A;
                end else if (req_b) begin
                    state_d = OWN_B;
                end
            end
            OWN_A: begin
                if (req_a && !last && !cap_hit) begin
                    cnt_en = 1'b1;
                end else begin
                    state_d = req_b ? OWN_B : IDLE;
                end
            end
            OWN_B: begin
                if (req_b && !last && !cap_hit) begin
                    cnt_en = 1'b1;
                end else begin
                    state_d = req_a ? OWN_A : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Entry into an owner state: restart the beat count, hand priority to the
        // other source, and move the mux select. Leaving to IDLE keeps sel as is.
        if ((state_d != state_q) && (state_d != IDLE)) begin
            cnt_clear = 1'b1;
            prio_d    = (state_d == OWN_A);
            sel_d     = (state_d == OWN_B) ? SEL_B : SEL_A;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            sel_q   <= SEL_A;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            sel_q   <= sel_d;
        end
    end

    assign sel     = sel_q;
    assign grant_a = (state_q == OWN_A);
    assign grant_b = (state_q == OWN_B);
    assign busy    = (state_q != IDLE);

endmodule

// File: doc/sel_arbiter.md
SEL_ARBITER -- requirements
Module: sel_arbiter

Interface
REQ-001 The module SHALL have parameter MAX_BEATS, default 8, giving the maximum beats per grant before forced release (legal range 1..15).
REQ-002 The module SHALL have parameter CNT_W, default 4, giving the beat counter width; it SHALL satisfy 2**CNT_W > MAX_BEATS.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port req_a, input, 1 bit: source A requests the 2:1 mux path.
REQ-006 Port req_b, input, 1 bit: source B requests the 2:1 mux path.
REQ-007 Port last, input, 1 bit: the current beat of the granted source is its final beat.
REQ-008 Port sel, output, 1 bit: the downstream mux select; 0 selects A, 1 selects B.
REQ-009 Port grant_a, output, 1 bit: A owns the mux this cycle.
REQ-010 Port grant_b, output, 1 bit: B owns the mux this cycle.
REQ-011 Port busy, output, 1 bit: a grant is active (grant_a | grant_b).

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, OWN_A, OWN_B; all outputs SHALL be registered or decoded directly from state, with no combinational path from any input to any output.
REQ-013 The FSM SHALL hold a one-bit round-robin pointer prio: 0 means A wins a tie, 1 means B wins a tie.
REQ-014 In IDLE with exactly one req high, the FSM SHALL enter that source's OWN state on the next edge (grant latency of 1 cycle).
REQ-015 In IDLE with both reqs high, the FSM SHALL enter OWN_A if prio=0, else OWN_B.
REQ-016 In OWN_x, each cycle with req_x=1 SHALL count as one beat, and the beat counter SHALL increment by 1.
REQ-017 A release condition SHALL be any of: req_x=1 and last=1; req_x=1 and the beat counter equals MAX_BEATS-1; or req_x=0 (source drop).
REQ-018 On release from OWN_x, if the other source's req is high in that same cycle, the FSM SHALL hand off directly to the other OWN state on the next edge with no IDLE bubble; otherwise it SHALL go to IDLE.
REQ-019 On every entry to an OWN state, the beat counter SHALL clear to 0 and prio SHALL be set to point at the source not granted.
REQ-020 sel SHALL be 0 in OWN_A and 1 in OWN_B, and SHALL hold its last value in IDLE so the mux output does not toggle while idle.
REQ-021 grant_a and grant_b SHALL never be high in the same cycle.
REQ-022 The beat counter SHALL never exceed MAX_BEATS-1, and SHALL not wrap while a grant is active.
REQ-023 For MAX_BEATS=1, every granted beat SHALL release, so the sources alternate each cycle when both request.
REQ-024 A last asserted while the FSM is in IDLE SHALL be ignored.

Reset
REQ-025 While rst is asserted, the block SHALL force state=IDLE, sel=0, grant_a=0, grant_b=0, busy=0, beat counter=0 and prio=0, asynchronously.
REQ-026 If reset is asserted mid-grant, the grant SHALL be abandoned immediately with no completion beat.
REQ-027 After reset deasserts, the first arbitration SHALL occur on the first rising edge that follows.

Structure
REQ-028 The state encoding (IDLE=2'd0, OWN_A=2'd1, OWN_B=2'd2) and the SEL_A=1'b0 / SEL_B=1'b1 constants SHALL reside in the shared package mux_pkg.
REQ-029 The beat counter SHALL be a sub-module, beat_counter (clear, enable, count, at_max).
REQ-030 The existing 2:1 mux SHALL be instantiated at top level, not inside sel_arbiter.

Verification
REQ-031 The bench SHALL cover: reset released, req_a=1 only -> grant_a=1 and sel=0 one cycle later; with last at beat 3, grant_a drops on the following edge and busy=0.
REQ-032 The bench SHALL cover: req_a=req_b=1 held constantly, MAX_BEATS=8, last=0 -> alternating grants of exactly 8 beats each, A first, with no idle cycle between grants.
REQ-033 The bench SHALL cover: OWN_B with sel=1, then req_b drops while req_a=0 -> IDLE, with sel remaining 1 and grants 0.
REQ-034 The bench SHALL cover: rst asserted asynchronously mid-OWN_B at beat 5 -> sel=0, grants=0 and busy=0 before the next edge; the next grant after release goes to A on a tie.
REQ-035 The bench SHALL cover: MAX_BEATS=1 with both reqs high -> grant alternates A,B,A,B on every cycle.
REQ-036 The bench SHALL cover the assertions: grant_a&grant_b never 1; the beat counter never reaches MAX_BEATS; sel constant throughout each grant.
